// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: SLL / SRA / ROR / SRL, one binary-weighted shift stage per amount bit.
// Latency: SHW cycles from acceptance to out_valid; one operation per cycle.
// Backpressure: valid/ready; bubbles collapse, in_ready falls only when every stage is full and out_ready=0.
module pipe_shifter #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_ROR = 2'b10,
    MODE_SRL = 2'b11
  } mode_e;

  // Per-stage state; index i holds stage i+1 (data already shifted by amt[i:0]).
  logic [SHW-1:0]   vld_q, vld_d;
  logic [SHW-1:0]   sign_q, sign_d;
  logic [1:0]       mode_q [SHW];
  logic [1:0]       mode_d [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [SHW-1:0]   amt_d  [SHW];
  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [SHW-1:0]   load;
  logic             unused_bits;

  // One fixed-distance step; sgn is the operand MSB captured at acceptance so
  // SRA fills correctly even after earlier stages have already shifted.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       m,
                                                  input logic             sgn,
                                                  input int               k);
    logic [WIDTH-1:0] r;
    r = d;
    case (mode_e'(m))
      MODE_SLL: r = d << k;
      MODE_SRA: r = (d >> k) | ({WIDTH{sgn}} << (WIDTH - k));
      MODE_ROR: r = (d >> k) | (d << (WIDTH - k));
      MODE_SRL: r = d >> k;
      default:  r = d;
    endcase
    return r;
  endfunction

  // A stage loads when any stage from it to the output is empty or the output
  // is being consumed; this is the unrolled form of "empty or leaving".
  for (genvar g = 0; g < SHW; g++) begin : g_load
    assign load[g] = out_ready | ~(&vld_q[SHW-1:g]);
  end

  assign in_ready  = load[0] & ~rst;
  assign out_valid = vld_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_zero  = out_valid & ~(|out_data);

  // Next state: every loading stage takes the previous stage (or the inputs) and applies its shift bit.
  always_comb begin
    vld_d  = vld_q;
    sign_d = sign_q;
    for (int i = 0; i < SHW; i++) begin
      mode_d[i] = mode_q[i];
      amt_d[i]  = amt_q[i];
      data_d[i] = data_q[i];
    end
    if (load[0]) begin
      vld_d[0]  = in_valid;
      mode_d[0] = in_mode;
      amt_d[0]  = in_amt;
      sign_d[0] = in_data[WIDTH-1];
      data_d[0] = in_amt[0] ? shift_step(in_data, in_mode, in_data[WIDTH-1], 1) : in_data;
    end
    for (int i = 1; i < SHW; i++) begin
      if (load[i]) begin
        vld_d[i]  = vld_q[i-1];
        mode_d[i] = mode_q[i-1];
        amt_d[i]  = amt_q[i-1];
        sign_d[i] = sign_q[i-1];
        data_d[i] = amt_q[i-1][i] ? shift_step(data_q[i-1], mode_q[i-1], sign_q[i-1], 1 << i)
                                  : data_q[i-1];
      end
    end
  end

  // Fields that are carried for uniformity but not consumed past their last use.
  always_comb begin
    unused_bits = sign_q[SHW-1] ^ (^mode_q[SHW-1]);
    for (int i = 0; i < SHW; i++) begin
      unused_bits = unused_bits ^ (^amt_q[i]);
    end
  end

  // Stage registers; only valid bits and the output data are cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q          <= '0;
      data_q[SHW-1]  <= '0;
    end else begin
      vld_q  <= vld_d;
      sign_q <= sign_d;
      for (int i = 0; i < SHW; i++) begin
        mode_q[i] <= mode_d[i];
        amt_q[i]  <= amt_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter (WIDTH=16): directed vectors plus randomized traffic
// against a plain-arithmetic shift model and an in-order expected-result queue.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pipe_shifter;

  localparam int W   = 16;
  localparam int SHW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SHW-1:0] in_amt = '0;
  logic [1:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  // Reference: 0 SLL, 1 SRA, 2 ROR, 3 SRL, written as plain shift arithmetic.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int a, input logic [1:0] m);
    logic [W-1:0] r;
    case (m)
      2'd0:    r = d << a;
      2'd1:    r = W'($signed(d) >>> a);
      2'd2:    r = (d >> a) | (d << (W - a));
      default: r = d >> a;
    endcase
    return r;
  endfunction

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic [SHW-1:0] a,
                       input logic [1:0] m, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_amt    = a;
    in_mode   = m;
    out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got=%b want=0", out_zero); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_latency();
    drive(1'b1, 16'h0001, 4'd15, 2'd0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_accept0 got=%b want=1", in_ready); end
    drive(1'b1, 16'h8000, 4'd15, 2'd3, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_accept1 got=%b want=1", in_ready); end
    for (int k = 2; k <= 6; k++) begin
      logic ev;
      logic [W-1:0] ed;
      drive(1'b0, 16'h0000, 4'd0, 2'd0, 1'b1);
      ev = (k == 4) || (k == 5);
      ed = (k == 4) ? 16'h8000 : 16'h0001;
      checks++;
      if (out_valid !== ev) begin errors++; $display("FAIL lat_valid cyc=%0d got=%b want=%b", k, out_valid, ev); end
      if (ev) begin
        checks++;
        if (out_data !== ed) begin errors++; $display("FAIL lat_data cyc=%0d got=%h want=%h", k, out_data, ed); end
      end
    end
  endtask

  task automatic test_modes();
    logic [W-1:0]   td [7] = '{16'h8000, 16'h7FF0, 16'h1234, 16'h1234, 16'h00FF, 16'h00FF, 16'h0001};
    logic [SHW-1:0] ta [7] = '{4'd4, 4'd4, 4'd4, 4'd0, 4'd8, 4'd15, 4'd1};
    logic [1:0]     tm [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3};
    logic [W-1:0]   te [7] = '{16'hF800, 16'h07FF, 16'h4123, 16'h1234, 16'hFF00, 16'h8000, 16'h0000};
    int idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 7) drive(1'b1, td[c], ta[c], tm[c], 1'b1);
      else       drive(1'b0, 16'h0000, 4'd0, 2'd0, 1'b1);
      if (c < 7) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL modes_accept op=%0d got=%b want=1", c, in_ready); end
      end
      if (out_valid === 1'b1 && idx < 7) begin
        checks++;
        if (out_data !== te[idx]) begin errors++; $display("FAIL modes_data op=%0d got=%h want=%h", idx, out_data, te[idx]); end
        checks++;
        if (out_zero !== (te[idx] == 16'h0000)) begin
          errors++; $display("FAIL modes_zero op=%0d got=%b want=%b", idx, out_zero, (te[idx] == 16'h0000));
        end
        idx++;
      end
    end
    checks++; if (idx != 7) begin errors++; $display("FAIL modes_count got=%0d want=7", idx); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]   bd [6];
    logic [SHW-1:0] ba [6];
    logic [1:0]     bm [6];
    logic [W-1:0]   held;
    int p = 0, e = 0, last = -10, ix;
    for (int k = 0; k < 6; k++) begin
      bd[k] = 16'h9F01 + 16'(k * 16'h0123);
      ba[k] = 4'(k + 1);
      bm[k] = 2'(k % 4);
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, bd[p], ba[p], bm[p], 1'b0);
      if (in_ready) p++;
    end
    checks++; if (p != 4) begin errors++; $display("FAIL bp_accepted got=%0d want=4", p); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    held = out_data;
    checks++;
    if (out_data !== ref_shift(bd[0], int'(ba[0]), bm[0])) begin
      errors++; $display("FAIL bp_first got=%h want=%h", out_data, ref_shift(bd[0], int'(ba[0]), bm[0]));
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, bd[p], ba[p], bm[p], 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold vld=%b data=%h rdy=%b want vld=1 data=%h rdy=0", out_valid, out_data, in_ready, held);
      end
    end
    for (int c = 0; c < 12; c++) begin
      ix = (p < 6) ? p : 0;
      drive(p < 6, bd[ix], ba[ix], bm[ix], 1'b1);
      if (out_valid === 1'b1) begin
        checks++;
        if (e >= 6 || out_data !== ref_shift(bd[e % 6], int'(ba[e % 6]), bm[e % 6])) begin
          errors++; $display("FAIL bp_order idx=%0d got=%h want=%h", e, out_data, ref_shift(bd[e % 6], int'(ba[e % 6]), bm[e % 6]));
        end
        if (e > 0) begin
          checks++;
          if (c != last + 1) begin errors++; $display("FAIL bp_gap idx=%0d cyc=%0d want=%0d", e, c, last + 1); end
        end
        last = c;
        e++;
      end
      if (in_valid && in_ready) p++;
    end
    checks++; if (e != 6) begin errors++; $display("FAIL bp_emitted got=%0d want=6", e); end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    logic [W-1:0] first = '0;
    drive(1'b1, 16'hAAAA, 4'd1, 2'd0, 1'b0);
    drive(1'b1, 16'h5555, 4'd2, 2'd3, 1'b0);
    drive(1'b1, 16'h1111, 4'd3, 2'd2, 1'b0);
    drive(1'b0, 16'h0000, 4'd0, 2'd0, 1'b0);
    drive(1'b0, 16'h0000, 4'd0, 2'd0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b want=1", out_valid); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL mid_data got=%h want=0000", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 16'hF0F0; in_amt = 4'd4; in_mode = 2'd3; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_first_accept got=%b want=1", in_ready); end
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 16'h0000, 4'd0, 2'd0, 1'b1);
      if (out_valid === 1'b1) begin
        if (seen == 0) first = out_data;
        seen++;
      end
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL mid_out_count got=%0d want=1", seen); end
    checks++; if (first !== 16'h0F0F) begin errors++; $display("FAIL mid_new_result got=%h want=0f0f", first); end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_d, held = '0;
    logic hold = 1'b0, exp_rdy;
    int ops = 0, cyc = 0, guard = 0;
    while (ops < 10000 && cyc < 60000) begin
      drive($urandom_range(0, 3) != 0, W'($urandom), SHW'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      cyc++;
      exp_rdy = (exp_q.size() < SHW) || out_ready;
      checks++;
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_rdy); end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++; $display("FAIL rnd_hold cyc=%0d vld=%b data=%h want=%h", cyc, out_valid, out_data, held);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_spurious cyc=%0d got=%h want=none", cyc, out_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (out_data !== exp_d || out_zero !== (exp_d == 16'h0000)) begin
            errors++; $display("FAIL rnd_data cyc=%0d got=%h/z%b want=%h", cyc, out_data, out_zero, exp_d);
          end
        end
      end
      hold = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, int'(in_amt), in_mode));
        ops++;
      end
    end
    checks++; if (ops != 10000) begin errors++; $display("FAIL rnd_ops got=%0d want=10000", ops); end
    while (exp_q.size() > 0 && guard < 50) begin
      drive(1'b0, 16'h0000, 4'd0, 2'd0, 1'b1);
      guard++;
      if (out_valid === 1'b1) begin
        exp_d = exp_q.pop_front();
        checks++;
        if (out_data !== exp_d) begin errors++; $display("FAIL rnd_drain got=%h want=%h", out_data, exp_d); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL have derived localparam SHW = log2(WIDTH), default 4, giving the shift-amount width and the pipeline depth.
REQ-003 The block SHALL have clk  input  1  as its single clock; all state updates on the rising edge.
REQ-004 The block SHALL have rst  input  1  as its reset; asynchronous, active-high.
REQ-005 The block SHALL have in_valid  input  1  meaning an operation is offered.
REQ-006 The block SHALL have in_ready  output  1  meaning stage 1 can accept this cycle.
REQ-007 The block SHALL have in_data  input  WIDTH  as the operand.
REQ-008 The block SHALL have in_amt  input  SHW  as the shift amount, 0..WIDTH-1.
REQ-009 The block SHALL have in_mode  input  2  as the operation: 00 SLL, 01 SRA, 10 ROR, 11 SRL.
REQ-010 The block SHALL have out_valid  output  1  meaning the result is present.
REQ-011 The block SHALL have out_ready  input  1  meaning the consumer accepts the result.
REQ-012 The block SHALL have out_data  output  WIDTH  as the shifted result.
REQ-013 The block SHALL have out_zero  output  1  asserted when out_data == 0 while out_valid=1, else 0.

Function
REQ-014 The block SHALL contain SHW register stages, where stage s (1..SHW) holds valid, mode, amt, and data already shifted by amt[s-1:0].
REQ-015 Stage s SHALL apply a shift of 2^(s-1) to its incoming data iff amt bit s-1 is 1; otherwise it passes the data through unchanged.
REQ-016 SLL SHALL shift in zeros at the LSB.
REQ-017 SRA SHALL fill the vacated MSBs with bit WIDTH-1 of the original in_data, captured at acceptance and carried down the pipeline.
REQ-018 SRL SHALL fill the vacated MSBs with zeros.
REQ-019 ROR SHALL move bits shifted out of the LSB into the MSB; amt=0 is the identity for every mode.
REQ-020 Stage SHW SHALL drive out_data and out_valid directly from registers, with no combinational path from in_* to out_*.
REQ-021 Each stage SHALL load when it is empty or when its own content leaves in that cycle; a stage leaves when the next stage loads it, or, for the last stage, when out_ready=1.
REQ-022 in_ready SHALL equal the stage-1 load condition; this may depend combinationally on out_ready through the stage chain.
REQ-023 An operation SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; no operation is accepted when in_valid=0, and stage 1 then becomes empty if it advances.
REQ-024 With no backpressure, an operation accepted at the end of cycle n SHALL produce out_valid in cycle n+SHW, and throughput SHALL be one operation per cycle.
REQ-025 Bubbles SHALL collapse: while out_ready=0, upstream stages keep advancing into empty stages, so a full pipe holds SHW operations.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_zero and out_valid SHALL be held stable.
REQ-027 Operations SHALL emerge in acceptance order, and none are dropped or duplicated.
REQ-028 Simultaneous accept and emit SHALL be supported in the same cycle while the pipe is full.

Reset
REQ-029 While rst=1, all stage valid bits SHALL clear immediately; out_valid=0 and out_zero=0.
REQ-030 While rst=1, out_data SHALL read 0 and in_ready SHALL read 0.
REQ-031 Reset mid-operation SHALL discard all in-flight operations with no partial output.
REQ-032 On the first rising edge after rst falls, in_ready SHALL be 1, and an operation offered then SHALL be accepted.
REQ-033 Data and mode registers need no reset; only the valid bits and out_data require it.

Verification (WIDTH=16)
REQ-034 Accept SLL 0x0001 amt 15 and SRL 0x8000 amt 15 back-to-back with out_ready=1 -> 0x8000 in cycle n+4 and 0x0001 in cycle n+5.
REQ-035 Accept SRA 0x8000 amt 4 -> 0xF800; SRA 0x7FF0 amt 4 -> 0x07FF; ROR 0x1234 amt 4 -> 0x4123; ROR 0x1234 amt 0 -> 0x1234.
REQ-036 Accept SLL 0x00FF amt 8 then SLL 0x00FF amt 15 -> 0xFF00 with out_zero=0, then 0x8000 with out_zero=0; then SRL 0x0001 amt 1 -> 0x0000 with out_zero=1.
REQ-037 Backpressure: hold out_ready=0 and offer 6 ops -> exactly 4 accepted and in_ready=0; first result held stable; raise out_ready -> all 6 emerge in order, one per cycle.
REQ-038 Reset mid-flight: assert rst asynchronously (between edges) with 3 ops in flight -> out_valid=0 immediately; after release, none of the old results ever appear.
REQ-039 Random: 10k ops with random mode, amt, in_valid and out_ready -> every result matches the reference shift model in order.
